// File: rtl/gas_scan_ctrl.sv
// gas_scan_ctrl: round-robin scan controller that time-shares one serial gas
// detector between NCH sensor channels. Each visit clears the detector (CLR),
// streams FRAME_LEN bits from the selected channel (FEED) and captures the
// 3-bit level code (CAPTURE). Results and per-channel alarms are registered.
//
// Optional build macro: GAS_SCAN_ALARM_LATCH_EN
//   undefined : alarm[ch] follows the latest capture of ch; alarm_clr ignored.
//   defined   : alarm[ch] is sticky, cleared (all bits) only by alarm_clr or reset.
module gas_scan_ctrl #(
   parameter  int NCH       = 4,
   parameter  int FRAME_LEN = 16,
   parameter  int ALARM_LVL = 3,
   localparam int CW        = (NCH > 2) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           arst,
   input  logic           start_en,
   input  logic [NCH-1:0] ch_din,
   input  logic           alarm_clr,
   output logic           det_rst,
   output logic           det_din,
   input  logic [2:0]     det_dout,
   output logic [CW-1:0]  ch_sel,
   output logic           busy,
   output logic           result_valid,
   output logic [CW-1:0]  result_ch,
   output logic [2:0]     result_code,
   output logic [NCH-1:0] alarm,
   output logic           scan_done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLR     = 2'd1,
      S_FEED    = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [7:0]     r_bit_cnt;
   logic [CW-1:0]  r_ch_sel;
   logic           r_result_valid;
   logic [CW-1:0]  r_result_ch;
   logic [2:0]     r_result_code;
   logic [NCH-1:0] r_alarm;
   logic           r_scan_done;

   logic w_last_bit;
   logic w_last_ch;
   logic w_hit;
   logic w_capture;

   assign w_last_bit = (r_bit_cnt == 8'(FRAME_LEN - 1));
   assign w_last_ch  = (r_ch_sel == CW'(NCH - 1));
   assign w_hit      = (det_dout >= 3'(ALARM_LVL));
   assign w_capture  = (r_state == S_CAPTURE);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic and detector control decode from the registered state.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_next  = r_state;
      det_rst = 1'b0;
      det_din = 1'b0;
      case (r_state)
         S_IDLE: begin
            det_rst = 1'b1;
            if (start_en) w_next = S_CLR;
         end
         S_CLR: begin
            det_rst = 1'b1;
            w_next  = S_FEED;
         end
         S_FEED: begin
            det_din = ch_din[r_ch_sel];
            if (w_last_bit) w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_next = start_en ? S_CLR : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Bit counter: counts FEED cycles, held at zero outside FEED.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst)                  r_bit_cnt <= '0;
      else if (r_state == S_FEED) r_bit_cnt <= r_bit_cnt + 8'd1;
      else                        r_bit_cnt <= '0;
   end

   // Capture the detector result, flag end of scan and advance the channel.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_ch_sel       <= '0;
         r_result_valid <= 1'b0;
         r_result_ch    <= '0;
         r_result_code  <= '0;
         r_scan_done    <= 1'b0;
      end else begin
         r_result_valid <= w_capture;
         r_scan_done    <= w_capture && w_last_ch;
         if (w_capture) begin
            r_result_code <= det_dout;
            r_result_ch   <= r_ch_sel;
            r_ch_sel      <= w_last_ch ? '0 : r_ch_sel + CW'(1);
         end
      end
   end

`ifdef GAS_SCAN_ALARM_LATCH_EN
   // Sticky alarms: a clear wipes all bits, a same-edge setting capture wins
   // for its own channel because its assignment comes last.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_alarm <= '0;
      end else begin
         if (alarm_clr) r_alarm <= '0;
         if (w_capture && w_hit) r_alarm[r_ch_sel] <= 1'b1;
      end
   end
`else
   // Tracking alarms: each capture rewrites its channel's flag.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst)          r_alarm <= '0;
      else if (w_capture) r_alarm[r_ch_sel] <= w_hit;
   end

   // alarm_clr has no function in this build.
   logic w_unused_alarm_clr;
   assign w_unused_alarm_clr = alarm_clr;
`endif

   assign ch_sel       = r_ch_sel;
   assign busy         = (r_state != S_IDLE);
   assign result_valid = r_result_valid;
   assign result_ch    = r_result_ch;
   assign result_code  = r_result_code;
   assign alarm        = r_alarm;
   assign scan_done    = r_scan_done;

endmodule

// File: tb/tb_gas_scan_ctrl.sv
// tb_gas_scan_ctrl: self-checking bench for gas_scan_ctrl (NCH=4, FRAME_LEN=16,
// ALARM_LVL=3). A visit-position model predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_gas_scan_ctrl;

   localparam int NCH       = 4;
   localparam int FRAME_LEN = 16;
   localparam int ALARM_LVL = 3;
   localparam int CW        = 2;
   localparam int VISIT     = FRAME_LEN + 2;

   logic           clk = 1'b0;
   logic           arst;
   logic           start_en;
   logic [NCH-1:0] ch_din;
   logic           alarm_clr;
   logic           det_rst;
   logic           det_din;
   logic [2:0]     det_dout;
   logic [CW-1:0]  ch_sel;
   logic           busy;
   logic           result_valid;
   logic [CW-1:0]  result_ch;
   logic [2:0]     result_code;
   logic [NCH-1:0] alarm;
   logic           scan_done;

   gas_scan_ctrl #(.NCH(NCH), .FRAME_LEN(FRAME_LEN), .ALARM_LVL(ALARM_LVL)) dut (
      .clk(clk), .arst(arst), .start_en(start_en), .ch_din(ch_din),
      .alarm_clr(alarm_clr), .det_rst(det_rst), .det_din(det_din),
      .det_dout(det_dout), .ch_sel(ch_sel), .busy(busy),
      .result_valid(result_valid), .result_ch(result_ch),
      .result_code(result_code), .alarm(alarm), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int tcyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_pos: -1 when idle, else position inside the current visit:
   // 0 = detector clear, 1..FRAME_LEN = feed bits, FRAME_LEN+1 = capture.
   int             m_pos   = -1;
   int             m_ch    = 0;
   logic           m_rv    = 1'b0;
   int             m_rch   = 0;
   logic [2:0]     m_rcode = 3'd0;
   logic [NCH-1:0] m_alarm = '0;
   logic           m_sd    = 1'b0;

   always @(posedge clk or negedge arst) begin
      if (!arst) begin
         m_pos = -1; m_ch = 0; m_rv = 1'b0; m_rch = 0;
         m_rcode = 3'd0; m_alarm = '0; m_sd = 1'b0;
      end else begin
         m_rv = 1'b0;
         m_sd = 1'b0;
`ifdef GAS_SCAN_ALARM_LATCH_EN
         if (alarm_clr) m_alarm = '0;
`endif
         if (m_pos < 0) begin
            if (start_en) m_pos = 0;
         end else if (m_pos == FRAME_LEN + 1) begin
            m_rv    = 1'b1;
            m_rch   = m_ch;
            m_rcode = det_dout;
`ifdef GAS_SCAN_ALARM_LATCH_EN
            if (int'(det_dout) >= ALARM_LVL) m_alarm[m_ch] = 1'b1;
`else
            m_alarm[m_ch] = (int'(det_dout) >= ALARM_LVL);
`endif
            m_sd  = (m_ch == NCH - 1);
            m_ch  = (m_ch + 1) % NCH;
            m_pos = start_en ? 0 : -1;
         end else begin
            m_pos++;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic exp_din;
      exp_din = (m_pos >= 1 && m_pos <= FRAME_LEN) ? ch_din[m_ch] : 1'b0;
      check("m_det_rst", 32'(det_rst), 32'(m_pos <= 0));
      check("m_det_din", 32'(det_din), 32'(exp_din));
      check("m_busy", 32'(busy), 32'(m_pos >= 0));
      check("m_ch_sel", 32'(ch_sel), m_ch);
      check("m_result_valid", 32'(result_valid), 32'(m_rv));
      check("m_result_ch", 32'(result_ch), m_rch);
      check("m_result_code", 32'(result_code), 32'(m_rcode));
      check("m_alarm", 32'(alarm), 32'(m_alarm));
      check("m_scan_done", 32'(scan_done), 32'(m_sd));
   end

   // ---------------- stimulus helpers ----------------
   logic [2:0]  code_tab [NCH];
   logic        rand_all = 1'b0;
   logic        rand_din = 1'b0;
   logic        pat_mode = 1'b0;
   logic [15:0] pat      = 16'hB0F0;

   // One clock: inputs change 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
      tcyc++;
      if (rand_all) begin
         start_en  = 1'($urandom);
         alarm_clr = 1'($urandom);
         det_dout  = 3'($urandom);
         ch_din    = NCH'($urandom);
      end else begin
         det_dout = code_tab[m_ch];
         if (rand_din) begin
            ch_din = NCH'($urandom);
         end else begin
            ch_din = '0;
            if (pat_mode && m_ch == 1 && m_pos >= 1 && m_pos <= FRAME_LEN)
               ch_din[1] = pat[FRAME_LEN - m_pos];
         end
      end
      #1;
   endtask

   task automatic wait_rv(input int limit);
      int k = 0;
      step();
      while (!result_valid && k < limit) begin
         step();
         k++;
      end
      check("wait_result_valid", 32'(result_valid), 1);
   endtask

   task automatic wait_ch_rv(input int ch);
      int k = 0;
      wait_rv(2 * VISIT);
      while (int'(result_ch) != ch && k < NCH + 1) begin
         wait_rv(2 * VISIT);
         k++;
      end
      check("wait_capture_ch", 32'(result_ch), ch);
   endtask

   task automatic wait_pos(input int ch, input int pos, input int limit);
      int k = 0;
      while (!(m_ch == ch && m_pos == pos) && k < limit) begin
         step();
         k++;
      end
      check("wait_visit_pos", 32'(m_ch == ch && m_pos == pos), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int          last_rv, last_sd, exp_ch, rst_cnt, other_ones, ch2_seen, n_sd;
      logic [15:0] cap;

      arst = 1'b0; start_en = 1'b0; alarm_clr = 1'b0; ch_din = '0; det_dout = 3'd0;
      code_tab[0] = 3'd1; code_tab[1] = 3'd2; code_tab[2] = 3'd5; code_tab[3] = 3'd0;

      // Reset held with random inputs.
      rand_all = 1'b1;
      repeat (6) step();
      check("rst_det_rst", 32'(det_rst), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_ch_sel", 32'(ch_sel), 0);
      check("rst_result_valid", 32'(result_valid), 0);
      check("rst_result_code", 32'(result_code), 0);
      check("rst_alarm", 32'(alarm), 0);
      check("rst_det_din", 32'(det_din), 0);
      check("rst_scan_done", 32'(scan_done), 0);

      rand_all = 1'b0; start_en = 1'b0; alarm_clr = 1'b0;
      step();
      arst = 1'b1;
      step();
      check("idle_busy", 32'(busy), 0);

      // Full scans with a bit pattern on ch1, codes {1,2,5,0}.
      pat_mode = 1'b1;
      start_en = 1'b1;
      last_rv = -1; last_sd = -1; exp_ch = 0; rst_cnt = 0;
      other_ones = 0; ch2_seen = 0; n_sd = 0; cap = '0;
      for (int i = 0; i < 150; i++) begin
         step();
         if (m_pos >= 1 && m_pos <= FRAME_LEN) begin
            if (m_ch == 1) cap = {cap[14:0], det_din};
            else if (det_din) other_ones++;
         end
         if (result_valid) begin
            check("scan_ch_seq", 32'(result_ch), exp_ch);
            exp_ch = (exp_ch + 1) % NCH;
            if (last_rv >= 0) check("rv_period", tcyc - last_rv, 18);
            last_rv = tcyc;
            check("clr_once_per_visit", rst_cnt, 1);
            rst_cnt = 0;
            if (result_ch == 1) begin
               check("ch1_routed_pattern", 32'(cap), 32'h0000_B0F0);
               cap = '0;
            end
            if (result_ch == 2) begin
               if (ch2_seen == 0) begin
                  check("ch2_code5", 32'(result_code), 5);
                  check("ch2_alarm_set", 32'(alarm), 32'b0100);
                  code_tab[2] = 3'd1;
               end else if (ch2_seen == 1) begin
                  check("ch2_code1", 32'(result_code), 1);
`ifdef GAS_SCAN_ALARM_LATCH_EN
                  check("ch2_alarm_sticky", 32'(alarm), 32'b0100);
`else
                  check("ch2_alarm_cleared", 32'(alarm), 32'b0000);
`endif
               end
               ch2_seen++;
            end
         end
         if (scan_done) begin
            check("scan_done_ch", 32'(result_ch), 3);
            if (last_sd >= 0) check("scan_done_period", tcyc - last_sd, 72);
            last_sd = tcyc;
            n_sd++;
         end
         if (det_rst && busy) rst_cnt++;
      end
      check("scan_done_count", n_sd, 2);
      check("other_ch_silent", other_ones, 0);
      check("ch0_after_wrap", 32'(ch_sel), 0);

      // Enable dropped at the 5th FEED cycle of ch1.
      pat_mode = 1'b0;
      rand_din = 1'b1;
      wait_pos(1, 5, 200);
      start_en = 1'b0;
      wait_rv(2 * VISIT);
      check("drop_capture_ch1", 32'(result_ch), 1);
      check("drop_busy", 32'(busy), 0);
      check("drop_ch_sel", 32'(ch_sel), 2);
      repeat (3) step();
      check("drop_idle_busy", 32'(busy), 0);
      check("drop_idle_ch_sel", 32'(ch_sel), 2);
      start_en = 1'b1;
      wait_rv(3 * VISIT);
      check("resume_ch2", 32'(result_ch), 2);

      // Alarm persistence and alarm_clr versus a same-edge capture.
      code_tab[0] = 3'd7; code_tab[1] = 3'd2; code_tab[2] = 3'd1; code_tab[3] = 3'd0;
      wait_ch_rv(0);
      check("ch0_code7", 32'(result_code), 7);
      check("ch0_alarm_set", 32'(alarm[0]), 1);
      code_tab[0] = 3'd0;
      wait_ch_rv(0);
`ifdef GAS_SCAN_ALARM_LATCH_EN
      check("ch0_alarm_persist", 32'(alarm[0]), 1);
`else
      check("ch0_alarm_follow", 32'(alarm[0]), 0);
`endif
      code_tab[3] = 3'd4;
      wait_pos(3, FRAME_LEN + 1, 4 * VISIT);
      alarm_clr = 1'b1;
      step();
      alarm_clr = 1'b0;
      check("clr_edge_rv", 32'(result_valid), 1);
      check("clr_edge_ch3", 32'(result_ch), 3);
      check("clr_edge_code4", 32'(result_code), 4);
      check("clr_edge_alarm", 32'(alarm), 32'b1000);
      repeat (3) step();
      alarm_clr = 1'b1;
      step();
      alarm_clr = 1'b0;
`ifdef GAS_SCAN_ALARM_LATCH_EN
      check("clr_alone_alarm", 32'(alarm), 32'b0000);
`else
      check("clr_ignored_alarm", 32'(alarm), 32'b1000);
`endif

      // Asynchronous reset in the middle of FEED.
      wait_pos(0, 8, 2 * VISIT);
      arst = 1'b0;
      #1;
      check("midfeed_rst_busy", 32'(busy), 0);
      check("midfeed_rst_ch_sel", 32'(ch_sel), 0);
      check("midfeed_rst_det_rst", 32'(det_rst), 1);
      check("midfeed_rst_alarm", 32'(alarm), 0);
      step();
      step();
      arst = 1'b1;
      wait_rv(2 * VISIT);
      check("post_rst_first_ch", 32'(result_ch), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gas_scan_ctrl.md
Name: gas_scan_ctrl

Overview:
Round-robin scan controller that time-shares one serial gas detector (3-bit level output) between NCH sensor channels. For each channel it clears the shared detector, streams FRAME_LEN bits from the selected channel into it, and captures the resulting level code. It publishes per-channel results and maintains a per-channel alarm vector. It sits between the sensor front-ends and the single detector instance.

Parameters:
NCH, 4, number of sensor channels (2..16)
FRAME_LEN, 16, serial bits fed to the detector per channel visit (1..255)
ALARM_LVL, 3, alarm threshold; code >= ALARM_LVL raises the alarm (0..7)

Ports:
clk  in  1  system clock, rising edge
arst  in  1  asynchronous reset, active-low (arst=0 resets)
start_en  in  1  scanning enable, level-sensitive
ch_din  in  NCH  serial bit per sensor channel, synchronous to clk
alarm_clr  in  1  single-cycle alarm clear; used only when the macro is defined
det_rst  out  1  reset to the shared detector, active-high
det_din  out  1  serial bit to the shared detector
det_dout  in  3  level code from the shared detector, registered in the detector
ch_sel  out  CW  selected channel, CW = max(1, clog2(NCH))
busy  out  1  high whenever the FSM is not in IDLE
result_valid  out  1  one-cycle pulse when a capture completes
result_ch  out  CW  channel of the last capture
result_code  out  3  code of the last capture
alarm  out  NCH  per-channel alarm flags
scan_done  out  1  one-cycle pulse on the capture of channel NCH-1

Behaviour:
- Reset (arst=0, asynchronous, any state): FSM=IDLE; ch_sel=0; det_rst=1; det_din=0; busy=0; result_valid=0; result_ch=0; result_code=0; alarm=0; scan_done=0.
- FSM states: IDLE, CLR, FEED, CAPTURE.
- IDLE: det_rst=1. If start_en=1, go to CLR next cycle.
- CLR: one cycle; det_rst=1; det_din=0. Next state is FEED with the bit counter at 0.
- FEED: exactly FRAME_LEN cycles; det_rst=0; det_din = ch_din[ch_sel] (combinational). The counter increments each cycle. Leave after count FRAME_LEN-1.
- CAPTURE: one cycle; det_rst=0; det_din=0. On this cycle's clock edge:
  - result_code <= det_dout; result_ch <= ch_sel; result_valid pulses on the following cycle.
  - alarm[ch_sel] is updated per the alarm rule (see Optional Feature).
  - scan_done pulses together with result_valid if ch_sel = NCH-1.
  - ch_sel advances by 1 and wraps NCH-1 -> 0.
  - Next state: CLR if start_en=1, else IDLE.
- Per-channel period: FRAME_LEN+2 cycles. A full scan takes NCH*(FRAME_LEN+2) cycles.
- Outputs result_valid, scan_done, result_* and alarm are registered. det_din and det_rst are decoded from state (registered state, combinational decode).
- Deasserting start_en mid-visit (CLR or FEED): the current channel runs to its capture, then the FSM goes to IDLE. ch_sel keeps the next channel; scanning resumes there when start_en returns.
- Channels other than ch_sel are ignored. ch_din is not synchronised inside this block.
- busy = (state != IDLE).

Optional Feature:
Macro: GAS_SCAN_ALARM_LATCH_EN
- Not defined: alarm[ch] <= (code >= ALARM_LVL) on every capture of ch, so the alarm clears on a later below-threshold capture. alarm_clr is ignored.
- Defined: alarm[ch] is sticky.
  - Set on a capture with code >= ALARM_LVL.
  - Cleared (all bits) only by alarm_clr=1 or by reset.
  - If alarm_clr and a setting capture occur on the same edge, the capturing channel's bit ends at 1 and all other bits clear.

Test Plan:
1. Reset check: hold arst=0 with random inputs -> all outputs at their reset values, det_rst=1, ch_sel=0. Assert arst=0 mid-FEED -> FSM returns to IDLE immediately and ch_sel=0.
2. Full scan (NCH=4, FRAME_LEN=16), start_en=1 after reset:
   - ch_sel sequence is 0,1,2,3,0.
   - det_rst is high for 1 cycle at each visit start.
   - result_valid pulses every 18 cycles.
   - scan_done pulses once per 72 cycles, with result_ch=3.
3. Bit routing: ch_din[1] driven with 1011_0000_1111_0000, other channels 0 -> det_din reproduces that pattern exactly during ch1's FEED and is 0 during the other channels' FEED.
4. Alarm, macro off: detector model returns 5 for ch2 -> result_ch=2, result_code=5, alarm=4'b0100. Next pass returns 1 for ch2 -> alarm=4'b0000.
5. Enable drop: start_en deasserted at the 5th FEED cycle of ch1 -> ch1 still captures, then IDLE with busy=0 and ch_sel=2. Re-enable -> the next capture is for ch2.
6. Alarm, macro on: ch0 code 7 -> alarm[0]=1 and it persists through a later code-0 capture. alarm_clr on the same edge as a ch3 capture with code 4 -> alarm=4'b1000.
